// File: rtl/majority_vote_filter.sv
// Sliding-window majority voter: CH independent 1-bit channels, each voting over its last WIN accepted samples.
// Latency: a sample accepted on edge k shows in maj/maj_valid/chg after that edge; no input-to-output comb path.
// Backpressure: none; one sample per clock when in_valid is held high, clr discards a coincident sample.
module majority_vote_filter #(
  parameter int CH       = 4,
  parameter int WIN      = 5,
  parameter bit TIE_HIGH = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [CH-1:0] in_bits,
  output logic [CH-1:0] maj,
  output logic          maj_valid,
  output logic [CH-1:0] chg
);

  // Count width holds 0..WIN; the vote compare is done one bit wider than WIN so 2*cnt never wraps.
  localparam int            CW    = $clog2(WIN + 1);
  localparam int            MW    = WIN + 1;
  localparam logic [CW-1:0] WIN_C = CW'(WIN);
  localparam logic [MW-1:0] WIN_M = MW'(WIN);

  logic [WIN-1:0] hist      [CH];
  logic [CW-1:0]  cnt       [CH];
  logic [CW-1:0]  fill;

  logic [WIN-1:0] hist_next [CH];
  logic [CW-1:0]  cnt_next  [CH];
  logic [CW-1:0]  fill_next;
  logic           vld_next;
  logic [CH-1:0]  maj_next;

  // More than half ones wins; an exact half (only possible for even WIN) resolves to TIE_HIGH.
  function automatic logic majority(input logic [CW-1:0] c);
    logic [MW-1:0] dbl;
    dbl = MW'(c) << 1;
    if (dbl > WIN_M) begin
      return 1'b1;
    end
    if ((WIN % 2 == 0) && (dbl == WIN_M)) begin
      return TIE_HIGH;
    end
    return 1'b0;
  endfunction

  // Candidate state if the current sample is accepted. The count update is exact in CW bits:
  // cnt never exceeds WIN, so any intermediate wrap cancels out.
  always_comb begin
    fill_next = (fill == WIN_C) ? fill : fill + CW'(1);
    vld_next  = (fill_next == WIN_C);
    maj_next  = '0;
    for (int i = 0; i < CH; i++) begin
      hist_next[i] = (hist[i] << 1) | WIN'(in_bits[i]);
      cnt_next[i]  = cnt[i] + CW'(in_bits[i]) - CW'(hist[i][WIN-1]);
      maj_next[i]  = vld_next & majority(cnt_next[i]);
    end
  end

  // Window state and registered outputs; clr wipes everything, idle cycles hold and drop chg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        hist[i] <= '0;
        cnt[i]  <= '0;
      end
      fill      <= '0;
      maj       <= '0;
      maj_valid <= 1'b0;
      chg       <= '0;
    end else if (clr) begin
      for (int i = 0; i < CH; i++) begin
        hist[i] <= '0;
        cnt[i]  <= '0;
      end
      fill      <= '0;
      maj       <= '0;
      maj_valid <= 1'b0;
      chg       <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < CH; i++) begin
        hist[i] <= hist_next[i];
        cnt[i]  <= cnt_next[i];
      end
      fill      <= fill_next;
      maj       <= maj_next;
      maj_valid <= vld_next;
      // The first entry into valid is not a change.
      chg       <= (maj_next ^ maj) & {CH{maj_valid & vld_next}};
    end else begin
      chg <= '0;
    end
  end

endmodule

// File: tb/tb_majority_vote_filter.sv
// Bench for majority_vote_filter: five instances with different CH/WIN/TIE_HIGH share one input stream.
// A window-of-samples reference model predicts every cycle's outputs into a scoreboard queue;
// a negedge monitor pops and compares, and also checks cnt against the popcount of hist.
module tb_majority_vote_filter;

  localparam int ND = 5;
  localparam int WINS [ND] = '{5, 3, 4, 4, 7};
  localparam int CHS  [ND] = '{4, 1, 2, 2, 8};
  localparam bit TIES [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_bits;

  logic [3:0] maj0, chg0;
  logic [0:0] maj1, chg1;
  logic [1:0] maj2, chg2, maj3, chg3;
  logic [7:0] maj4, chg4;
  logic       vld0, vld1, vld2, vld3, vld4;

  majority_vote_filter #(.CH(4), .WIN(5), .TIE_HIGH(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bits(in_bits[3:0]),
    .maj(maj0), .maj_valid(vld0), .chg(chg0));
  majority_vote_filter #(.CH(1), .WIN(3), .TIE_HIGH(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bits(in_bits[0:0]),
    .maj(maj1), .maj_valid(vld1), .chg(chg1));
  majority_vote_filter #(.CH(2), .WIN(4), .TIE_HIGH(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bits(in_bits[1:0]),
    .maj(maj2), .maj_valid(vld2), .chg(chg2));
  majority_vote_filter #(.CH(2), .WIN(4), .TIE_HIGH(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bits(in_bits[1:0]),
    .maj(maj3), .maj_valid(vld3), .chg(chg3));
  majority_vote_filter #(.CH(8), .WIN(7), .TIE_HIGH(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bits(in_bits),
    .maj(maj4), .maj_valid(vld4), .chg(chg4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [ND-1:0][7:0] maj;
    logic [ND-1:0][7:0] chg;
    logic [ND-1:0]      vld;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mdl;
  logic [7:0] sq[$];      // samples accepted since the last reset/clr, newest at the back
  logic       cur_r, cur_c, cur_v;
  logic [7:0] cur_b;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, k, $time, act, expv);
    end
  endtask

  // Majority over the newest WINS[k] samples of each channel, by plain counting.
  function automatic logic [7:0] vote(input int k);
    logic [7:0] m;
    m = '0;
    for (int c = 0; c < CHS[k]; c++) begin
      int ones;
      ones = 0;
      for (int j = 0; j < WINS[k]; j++) ones += int'(sq[sq.size() - 1 - j][c]);
      m[c] = (2 * ones > WINS[k]) || ((2 * ones == WINS[k]) && TIES[k]);
    end
    return m;
  endfunction

  // Effect of one rising edge with the inputs that were being driven into it.
  task automatic model_edge();
    logic       nv;
    logic [7:0] nm;
    if (!cur_r || cur_c) begin
      sq.delete();
      mdl = '0;
    end else if (cur_v) begin
      sq.push_back(cur_b);
      if (sq.size() > 32) void'(sq.pop_front());
      for (int k = 0; k < ND; k++) begin
        nv = (sq.size() >= WINS[k]);
        nm = nv ? vote(k) : 8'h00;
        mdl.chg[k] = (mdl.vld[k] && nv) ? (nm ^ mdl.maj[k]) : 8'h00;
        mdl.maj[k] = nm;
        mdl.vld[k] = nv;
      end
    end else begin
      mdl.chg = '0;
    end
  endtask

  // One clock of stimulus: apply the edge to the model, drive new inputs, predict this cycle's outputs.
  task automatic step(input logic r, input logic c, input logic v, input logic [7:0] b);
    @(posedge clk);
    model_edge();
    #1;
    rst_n = r; clr = c; in_valid = v; in_bits = b;
    cur_r = r; cur_c = c; cur_v = v; cur_b = b;
    if (!r) begin
      sq.delete();
      mdl = '0;
    end
    exp_q.push_back(mdl);
  endtask

  exp_t               e;
  logic [ND-1:0][7:0] am, ac;
  logic [ND-1:0]      av;

  // Monitor: every cycle that has a prediction, compare all instances and the count invariant.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      am[0] = 8'(maj0); ac[0] = 8'(chg0); av[0] = vld0;
      am[1] = 8'(maj1); ac[1] = 8'(chg1); av[1] = vld1;
      am[2] = 8'(maj2); ac[2] = 8'(chg2); av[2] = vld2;
      am[3] = 8'(maj3); ac[3] = 8'(chg3); av[3] = vld3;
      am[4] = maj4;     ac[4] = chg4;     av[4] = vld4;
      for (int k = 0; k < ND; k++) begin
        chk("maj", k, 32'(am[k]), 32'(e.maj[k]));
        chk("maj_valid", k, 32'(av[k]), 32'(e.vld[k]));
        chk("chg", k, 32'(ac[k]), 32'(e.chg[k]));
      end
      for (int i = 0; i < 4; i++) chk("cnt_popcount_u0", i, 32'(u0.cnt[i]), 32'($countones(u0.hist[i])));
      for (int i = 0; i < 8; i++) chk("cnt_popcount_u4", i, 32'(u4.cnt[i]), 32'($countones(u4.hist[i])));
    end
  end

  logic [7:0] tt_seq [7] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bits = 8'h00;
    cur_r = 1'b0; cur_c = 1'b0; cur_v = 1'b0; cur_b = 8'h00;
    mdl = '0;

    // Reset, then idle with in_valid low.
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (10) step(1'b1, 1'b0, 1'b0, 8'h00);

    // Fill with a constant pattern, then one idle cycle.
    repeat (5) step(1'b1, 1'b0, 1'b1, 8'h0B);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Truth-table sweep on channel 0 after a clear.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, tt_seq[i]);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Gaps between accepts, clr with a coincident sample, then refill.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, (i % 2 == 0), 8'($urandom));
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom));
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Even-window tie on bits 1:0: 1,1,0,0.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h03);
    step(1'b1, 1'b0, 1'b1, 8'h03);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset while windows are full, then refill.
    repeat (9) step(1'b1, 1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom));

    // Random soak.
    for (int n = 0; n < 10000; n++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 70, 8'($urandom));
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
